// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage data-access controller:
// load-extend codes, controller states, store byte patterns and the
// alignment rule used to decide whether a bus cycle may be issued.
package mem_pkg;

  typedef enum logic [2:0] {
    EXT_W  = 3'd0,
    EXT_B  = 3'd1,
    EXT_BU = 3'd2,
    EXT_H  = 3'd3,
    EXT_HU = 3'd4
  } ext_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] WE_NONE = 4'b0000;
  localparam logic [3:0] WE_BYTE = 4'b0001;
  localparam logic [3:0] WE_HALF = 4'b0011;
  localparam logic [3:0] WE_WORD = 4'b1111;

  // Access size comes from the extend op for loads and from the byte
  // pattern for stores; anything that is neither byte nor half is a word.
  function automatic logic is_misaligned(input logic       is_load,
                                         input logic [3:0] we,
                                         input logic [2:0] ext,
                                         input logic [1:0] lo);
    logic half;
    logic word;
    if (is_load) begin
      half = (ext == EXT_H) || (ext == EXT_HU);
      word = !(half || (ext == EXT_B) || (ext == EXT_BU));
    end else begin
      half = (we == WE_HALF);
      word = !(half || (we == WE_BYTE));
    end
    return (half && lo[0]) || (word && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension of the raw bus read word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  ext_op,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed byte/half lane, then extend according to the op.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case statements can leave it unassigned (latch).
    byte_v = rdata[7:0];
    data   = rdata;
    case (lane)
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      2'd3:    byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (ext_op)
      EXT_B:   data = {{24{byte_v[7]}}, byte_v};
      EXT_BU:  data = {24'd0, byte_v};
      EXT_H:   data = {{16{half_v[15]}}, half_v};
      EXT_HU:  data = {16'd0, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access.sv
// Memory-stage data-access controller: issues req/ack/rvalid bus cycles for
// the EX/MEM slot, aligns store/load data, stalls upstream while busy.
// Optional LL/SC link tracking is enabled by defining DMEM_LLSC_EN.
module dmem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              valid_in,
  input  logic              mem_rd_in,
  input  logic [3:0]        ram_we_in,
  input  logic [2:0]        ram_ext_op_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              ll_in,
  input  logic              sc_in,
  output logic              suspend,
  output logic              dbus_req,
  output logic [3:0]        dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  input  logic              dbus_ack,
  input  logic              dbus_rvalid,
  input  logic [31:0]       dbus_rdata,
  output logic [31:0]       ld_data_out,
  output logic              res_valid_out,
  output logic              mem_err_out
);

  state_e      state;
  logic [1:0]  lane_q;
  logic [2:0]  ext_q;
  logic        load_q;
  logic        sc_q;
  logic        start;
  logic        is_load;
  logic        misalign;
  logic        sc_fail;
  logic        ld_capture;
  logic [3:0]  we_shift;
  logic [31:0] wdata_rep;
  logic [31:0] aligned;

  assign is_load    = mem_rd_in;
  assign start      = (state == IDLE) && valid_in && (mem_rd_in || (ram_we_in != WE_NONE));
  assign misalign   = is_misaligned(is_load, ram_we_in, ram_ext_op_in, addr_in[1:0]);
  assign suspend    = start || (state == REQ) || (state == WAIT_R);
  assign we_shift   = ram_we_in << addr_in[1:0];
  assign ld_capture = load_q && dbus_rvalid &&
                      (((state == REQ) && dbus_ack) || (state == WAIT_R));

  // Replicate store data across all lanes so any byte enable finds it.
  always_comb begin
    wdata_rep = wdata_in;
    case (ram_we_in)
      WE_BYTE: wdata_rep = {4{wdata_in[7:0]}};
      WE_HALF: wdata_rep = {2{wdata_in[15:0]}};
      default: wdata_rep = wdata_in;
    endcase
  end

  load_align u_load_align (
    .rdata  (dbus_rdata),
    .lane   (lane_q),
    .ext_op (ext_q),
    .data   (aligned)
  );

`ifdef DMEM_LLSC_EN
  logic              link_valid;
  logic [ADDR_W-3:0] link_addr;
  logic              ll_q;

  assign sc_fail = sc_in && !is_load &&
                   !(link_valid && (link_addr == addr_in[ADDR_W-1:2]));

  // Link register: set when an LL load returns data, cleared by every SC
  // and by any store this unit performs to the linked word.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
      ll_q       <= 1'b0;
    end else if (start) begin
      ll_q <= ll_in && is_load && !misalign;
      if (!is_load && (sc_in || (!misalign && link_valid &&
                                 (link_addr == addr_in[ADDR_W-1:2]))))
        link_valid <= 1'b0;
    end else if (ll_q && ld_capture) begin
      link_valid <= 1'b1;
      link_addr  <= dbus_addr[ADDR_W-1:2];
    end
  end
`else
  logic ll_unused;
  assign ll_unused = ll_in;
  assign sc_fail   = 1'b0;
`endif

  // Access FSM with registered bus and result outputs.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      // NOTE: state and outputs use non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state         <= IDLE;
      dbus_req      <= 1'b0;
      dbus_we       <= WE_NONE;
      dbus_addr     <= '0;
      dbus_wdata    <= '0;
      ld_data_out   <= '0;
      res_valid_out <= 1'b0;
      mem_err_out   <= 1'b0;
      lane_q        <= '0;
      ext_q         <= '0;
      load_q        <= 1'b0;
      sc_q          <= 1'b0;
    end else begin
      res_valid_out <= 1'b0;
      mem_err_out   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            lane_q <= addr_in[1:0];
            ext_q  <= ram_ext_op_in;
            load_q <= is_load;
            sc_q   <= sc_in && !is_load;
            if (misalign) begin
              state         <= DONE;
              res_valid_out <= 1'b1;
              mem_err_out   <= 1'b1;
            end else if (sc_fail) begin
              state         <= DONE;
              res_valid_out <= 1'b1;
              ld_data_out   <= 32'd0;
            end else begin
              state      <= REQ;
              dbus_req   <= 1'b1;
              dbus_we    <= is_load ? WE_NONE : we_shift;
              dbus_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
              dbus_wdata <= wdata_rep;
            end
          end
        end
        REQ: begin
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            dbus_we  <= WE_NONE;
            if (!load_q) begin
              state         <= DONE;
              res_valid_out <= 1'b1;
              if (sc_q) ld_data_out <= 32'd1;
            end else if (ld_capture) begin
              state         <= DONE;
              res_valid_out <= 1'b1;
              ld_data_out   <= aligned;
            end else begin
              state <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (ld_capture) begin
            state         <= DONE;
            res_valid_out <= 1'b1;
            ld_data_out   <= aligned;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_access.md
# dmem_access

Memory-stage data-access controller. It consumes the request fields that the EX/MEM pipeline register carries: valid, address, store data, byte-write pattern, load-extend op and LL/SC flags. It drives a req/ack/rvalid data bus, aligns store data and load data, and maintains the LL/SC link. It produces the extended load value and the SC result for the MEM/WB path. While an access is outstanding it raises `suspend` to freeze the upstream pipeline registers.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width.

Ports:
- `cpu_clk`  in  1  sole clock, rising edge.
- `cpu_rst`  in  1  synchronous, active-high reset.
- `valid_in`  in  1  EX/MEM slot holds a live instruction.
- `mem_rd_in`  in  1  instruction is a load (incl. LL).
- `ram_we_in`  in  4  unshifted store pattern: 0001 byte, 0011 half, 1111 word, 0000 no store.
- `ram_ext_op_in`  in  3  load extend op (package codes).
- `addr_in`  in  ADDR_W  effective address (ALU result).
- `wdata_in`  in  32  store source register value.
- `ll_in`, `sc_in`  in  1  LL / SC instruction.
- `suspend`  out  1  stall request to PC/IF_ID/ID_EX/EX_MEM.
- `dbus_req`  out  1  bus request, held until `dbus_ack`.
- `dbus_we`  out  4  shifted byte enables; 0 = read.
- `dbus_addr`  out  ADDR_W  word-aligned address.
- `dbus_wdata`  out  32  lane-replicated store data.
- `dbus_ack`  in  1  request accepted this cycle.
- `dbus_rvalid`  in  1  read data valid.
- `dbus_rdata`  in  32  raw read word.
- `ld_data_out`  out  32  extended load result, or SC result (0/1).
- `res_valid_out`  out  1  `ld_data_out` valid this cycle.
- `mem_err_out`  out  1  misaligned access, no bus transaction issued.

## Operation
- Access start: IDLE with `valid_in` and (`mem_rd_in` or `ram_we_in`≠0).
- Misalignment (half with addr[0]=1, word with addr[1:0]≠0): no bus cycle; `mem_err_out`=1 for one cycle via DONE; `suspend` is not asserted beyond the start cycle.
- Stores: `dbus_we` = `ram_we_in << addr[1:0]`; byte data replicated ×4, half ×2.
- Loads: select lane by addr[1:0] and extend per op. EXT_W=0, EXT_B=1 (sign), EXT_BU=2, EXT_H=3 (sign), EXT_HU=4; others behave as EXT_W.
- FSM states:
  - IDLE: on start, → REQ (or → DONE on misalign/SC-fail).
  - REQ: `dbus_req`=1. On `dbus_ack`, a store → DONE. For a load, `dbus_rvalid` in the same cycle → DONE, else → WAIT_R.
  - WAIT_R: on `dbus_rvalid`, capture data → DONE.
  - DONE: `res_valid_out`=1, `suspend`=0, → IDLE unconditionally. The held instruction leaves EX/MEM at this edge and must not restart.
- `suspend` = (IDLE and start) or REQ or WAIT_R.
- Bus outputs are registered when entering REQ and are stable while `dbus_req`=1.
- `ld_data_out` holds its value except on capture.

## Timing
- Reset: state IDLE; `suspend`, `dbus_req`, `dbus_we`, `res_valid_out`, `mem_err_out` = 0; `dbus_addr`, `dbus_wdata`, `ld_data_out` = 0; link cleared.
- Minimum latency with ack in the first REQ cycle:
  - Store: start→REQ→DONE, 3 cycles.
  - Load with rvalid coincident with ack: 3 cycles.
- `dbus_rvalid` outside REQ/WAIT_R is ignored.
- Reset during REQ/WAIT_R aborts immediately: `dbus_req` drops the next edge and late rvalid is ignored.

## Configuration
- `DMEM_LLSC_EN` defined:
  - LL performs a load and sets `link_valid` and `link_addr`=addr[31:2].
  - SC with `link_valid` and a matching word stores normally; result 1.
  - Otherwise SC issues no bus cycle and goes IDLE→DONE; result 0.
  - Every SC clears the link. Any store by this unit to the linked word also clears it.
- `DMEM_LLSC_EN` undefined: LL is a plain load, SC is a plain store with result 1, and there is no link state.

## Structure
- Package `mem_pkg`: ext-op codes (EXT_W…EXT_HU), state enum (IDLE, REQ, WAIT_R, DONE), store patterns.
- Sub-module `load_align`: combinational lane select plus extend from (rdata, addr[1:0], ext_op).

## Test plan
- LB: addr 0x1003, rdata 0x80FF_0000 → `ld_data_out`=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH: addr 0x2002, wdata 0x0000_BEEF, ack after 2 wait cycles → `dbus_we`=1100, `dbus_wdata`=0xBEEF_BEEF, `suspend` high 4 cycles.
- LW with ack and rvalid coincident: `res_valid_out` in cycle 3; data 0x1234_5678 passes through unchanged.
- LL 0x3000 then SC 0x3000 → bus store and result 1. A second SC → no `dbus_req`, result 0. With the macro off → result 1.
- LH at 0x4001 → `mem_err_out`=1, `dbus_req` never asserted.
- `cpu_rst` in WAIT_R, then rvalid → state IDLE, `res_valid_out` stays 0.
